// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: two requesters share one EN_Adder (8-bit ripple adder
// with a tri-state result bus). Round-robin arbitration, operands latched at
// grant, adder output enabled only in CALC, registered 9-bit result returned
// with a one-cycle ack to the owning requester.
// Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed priority (req0 always
// wins contention, no round-robin pointer).

// Ripple-carry adder whose result is driven onto a tri-state bus while en=1.
module en_adder #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output wire  [WIDTH:0]   y
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  // Bus floats whenever the adder is not enabled.
  assign y = en ? {c[WIDTH], s} : {(WIDTH+1){1'bz}};
endmodule

module adder_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH:0]   sum,
  output logic             owner,
  output logic             busy,
  output logic             adder_en
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value on the final CALC edge, when the bus is captured.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_op_q, a_op_d;
  logic [WIDTH-1:0] b_op_q, b_op_d;
  logic             grant_q, grant_d;   // requester whose op is in flight
  logic             owner_q, owner_d;   // requester whose result is on sum
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             win;
  wire  [WIDTH:0]   adder_bus;

  en_adder #(.WIDTH(WIDTH)) u_adder (
    .en (state_q == CALC),
    .a  (a_op_q),
    .b  (b_op_q),
    .y  (adder_bus)
  );

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Fixed priority: req0 wins whenever it is asserted.
  always_comb begin
    win = ~req0;
  end
`else
  logic rr_q, rr_d;   // last requester served; the other wins a tie

  // Round-robin: on contention the requester not served last wins.
  always_comb begin
    win = (req0 & req1) ? ~rr_q : req1;
  end
`endif

  // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_op_d  = a_op_q;
    b_op_d  = b_op_q;
    grant_d = grant_q;
    owner_d = owner_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d = win;
          a_op_d  = win ? a1 : a0;
          b_op_d  = win ? b1 : b0;
          cnt_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == HOLD_LAST) begin
          sum_d   = adder_bus;
          owner_d = grant_q;
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
`ifndef ADDER_ARB_FIXED_PRIO_EN
        rr_d    = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any op in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_op_q  <= '0;
      b_op_q  <= '0;
      grant_q <= 1'b0;
      owner_q <= 1'b0;
      sum_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cnt_q   <= 4'd0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_op_q  <= a_op_d;
      b_op_q  <= b_op_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      sum_q   <= sum_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      cnt_q   <= cnt_d;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Outputs come straight from flops or from the state decode.
  always_comb begin
    ack0     = ack0_q;
    ack1     = ack1_q;
    sum      = sum_q;
    owner    = owner_q;
    busy     = (state_q != IDLE);
    adder_en = (state_q == CALC);
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed scenarios followed by random
// two-requester traffic, checked against a transaction-level reference model.
module tb_adder_share_arbiter;
  localparam int HOLD = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       r_v [2];
  logic [7:0] a_v [2];
  logic [7:0] b_v [2];
  logic       ack0, ack1, owner, busy, adder_en;
  logic [8:0] sum;

  int total = 0;
  int bad   = 0;

  adder_share_arbiter #(.WIDTH(8), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (r_v[0]),
    .a0       (a_v[0]),
    .b0       (b_v[0]),
    .req1     (r_v[1]),
    .a1       (a_v[1]),
    .b1       (b_v[1]),
    .ack0     (ack0),
    .ack1     (ack1),
    .sum      (sum),
    .owner    (owner),
    .busy     (busy),
    .adder_en (adder_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: an op granted at edge g captures at edge g+HOLD and
  // frees the adder at edge g+HOLD+1.
  int         edge_n;
  bit         inflight;
  bit         m_win;
  bit         m_last;
  int         m_grant;
  logic [8:0] m_opsum;
  logic [8:0] m_sum;
  bit         m_owner, m_ack0, m_ack1, m_busy, m_en;

  function automatic void model_reset();
    edge_n   = 0;
    inflight = 0;
    m_last   = 1'b1;
    m_sum    = '0;
    m_owner  = 1'b0;
    m_ack0   = 1'b0;
    m_ack1   = 1'b0;
    m_busy   = 1'b0;
    m_en     = 1'b0;
  endfunction

  function automatic void model_edge(input bit r0, input bit r1,
                                     input logic [7:0] x0, input logic [7:0] y0,
                                     input logic [7:0] x1, input logic [7:0] y1);
    edge_n++;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (inflight && edge_n == m_grant + HOLD + 1) begin
      inflight = 0;
      m_last   = m_win;
    end else if (inflight && edge_n == m_grant + HOLD) begin
      m_sum   = m_opsum;
      m_owner = m_win;
      m_ack0  = !m_win;
      m_ack1  = m_win;
    end else if (!inflight && (r0 || r1)) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      m_win = r0 ? 1'b0 : 1'b1;
`else
      m_win = (r0 && r1) ? !m_last : r1;
`endif
      m_opsum  = m_win ? 9'(int'(x1) + int'(y1)) : 9'(int'(x0) + int'(y0));
      m_grant  = edge_n;
      inflight = 1;
    end
    m_busy = inflight;
    m_en   = inflight && (edge_n < m_grant + HOLD);
  endfunction

  // One clock edge: advance model with the inputs the DUT samples, then compare.
  task automatic step();
    bit         r0, r1;
    logic [7:0] x0, y0, x1, y1;
    r0 = r_v[0]; r1 = r_v[1];
    x0 = a_v[0]; y0 = b_v[0]; x1 = a_v[1]; y1 = b_v[1];
    @(posedge clk);
    #1;
    model_edge(r0, r1, x0, y0, x1, y1);
    chk("ack0", ack0, m_ack0);
    chk("ack1", ack1, m_ack1);
    chk("sum", sum, m_sum);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_busy);
    chk("adder_en", adder_en, m_en);
    chk("ack_exclusive", ack0 & ack1, 0);
    if (ack0 || ack1)
      $display("op edge=%0d owner=%0d sum=%03h", edge_n, owner, sum);
  endtask

  // Step until an ack appears, bounded.
  task automatic serve_wait(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(ack0 || ack1) && n < 20);
    if (!(ack0 || ack1)) chk("ack_timeout", ack0 | ack1, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      r_v[r] = 1'b0; a_v[r] = '0; b_v[r] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  bit pend [2];

  initial begin
    int n;
    do_reset();
    chk("rst_sum", sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);

    // 1) single requester 0
    r_v[0] = 1'b1; a_v[0] = 8'h7F; b_v[0] = 8'h01;
    serve_wait(n);
    chk("t1_latency", n, HOLD + 1);
    chk("t1_ack0", ack0, 1);
    chk("t1_sum", sum, 9'h080);
    r_v[0] = 1'b0;
    step();

    // 2) single requester 1, carry out
    r_v[1] = 1'b1; a_v[1] = 8'hFF; b_v[1] = 8'hFF;
    serve_wait(n);
    chk("t2_ack1", ack1, 1);
    chk("t2_sum", sum, 9'h1FE);
    chk("t2_owner", owner, 1);
    r_v[1] = 1'b0;
    step();

    // 3) contention from reset, then both held continuously
    do_reset();
    r_v[0] = 1'b1; a_v[0] = 8'd1; b_v[0] = 8'd2;
    r_v[1] = 1'b1; a_v[1] = 8'd2; b_v[1] = 8'd3;
    serve_wait(n);
    chk("t3_first_ack0", ack0, 1);
    chk("t3_first_sum", sum, 9'd3);
    r_v[0] = 1'b0;
    serve_wait(n);
    chk("t3_second_gap", n, HOLD + 2);
    chk("t3_second_ack1", ack1, 1);
    chk("t3_second_sum", sum, 9'd5);
    r_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve_wait(n);
`ifdef ADDER_ARB_FIXED_PRIO_EN
      chk("t3_fixed_owner", owner, 0);
`else
      chk("t3_alt_owner", owner, i % 2);
`endif
    end
    r_v[0] = 1'b0; r_v[1] = 1'b0;
    step(); step();

    // 4) operand change after grant is ignored
    r_v[0] = 1'b1; a_v[0] = 8'h10; b_v[0] = 8'h20;
    step();
    a_v[0] = 8'hFF;
    serve_wait(n);
    chk("t4_sum", sum, 9'h030);
    r_v[0] = 1'b0;
    step();

    // 5) reset in the middle of CALC
    r_v[0] = 1'b1; a_v[0] = 8'h55; b_v[0] = 8'h11;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_sum", sum, 0);
    chk("t5_ack0", ack0, 0);
    chk("t5_busy", busy, 0);
    chk("t5_adder_en", adder_en, 0);
    @(posedge clk);
    #1;
    chk("t5_hold_ack0", ack0, 0);
    rst = 1'b0;
    r_v[0] = 1'b0;
    model_reset();
    step();
    r_v[0] = 1'b1; a_v[0] = 8'd3; b_v[0] = 8'd4;
    serve_wait(n);
    chk("t5_after_sum", sum, 9'd7);
    r_v[0] = 1'b0;
    step();

    // Random traffic
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        bit acked;
        acked = (r == 0) ? ack0 : ack1;
        if (acked) begin
          r_v[r] = 1'b0; pend[r] = 0;
        end else if (!pend[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            r_v[r] = 1'b1; pend[r] = 1;
            a_v[r] = 8'($urandom); b_v[r] = 8'($urandom);
          end
        end else if (inflight && m_win == 1'(r) && edge_n < m_grant + HOLD) begin
          if ($urandom_range(0, 15) == 0) begin
            r_v[r] = 1'b0; pend[r] = 0;
          end else if ($urandom_range(0, 1) == 0) begin
            a_v[r] = 8'($urandom); b_v[r] = 8'($urandom);
          end
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
